// File: rtl/score_bcd_sequencer.sv
// Score sequencer: accepts saturated binary scores, converts them to BCD with a
// bit-serial double-dabble, keeps a high score and drives six active-low HEX digits.
// Optional build macro HISCORE_FLASH_EN blinks the high-score digits after a new record.
module score_bcd_sequencer #(
    parameter int MAX_SCORE    = 999,
    parameter int CONV_BITS    = 10,
    parameter int FLASH_PERIOD = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        score_valid,
    input  logic [31:0] score_count,
    output logic        score_ready,
    input  logic        clear_hiscore,
    output logic        busy,
    output logic [11:0] score_BCD,
    output logic [11:0] hiscore_BCD,
    output logic        new_hiscore,
    output logic [41:0] seven_seg
);

    // Handshake: an update is taken on any rising edge where score_valid && score_ready;
    // the requester holds score_valid/score_count stable until then, nothing is queued.

    localparam int CNT_W = $clog2(CONV_BITS + 1);

    if (MAX_SCORE > 999 || FLASH_PERIOD < 1) begin : g_bad_cfg
        $error("score_bcd_sequencer: MAX_SCORE must fit in 3 BCD digits and FLASH_PERIOD must be positive");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CONV_BITS-1:0] sat_q;
    logic [CONV_BITS-1:0] bin_sh;
    logic [11:0]          bcd_sh;
    logic [11:0]          bcd_adj;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CONV_BITS-1:0] hi_bin;
    logic [CONV_BITS-1:0] sat_in;
    logic                 blank_hi;

    assign sat_in = (score_count > 32'(MAX_SCORE)) ? CONV_BITS'(MAX_SCORE)
                                                   : score_count[CONV_BITS-1:0];

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    assign bcd_adj = {add3(bcd_sh[11:8]), add3(bcd_sh[7:4]), add3(bcd_sh[3:0])};

    always_comb begin
        state_next  = state;
        score_ready = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                score_ready = 1'b1;
                busy        = 1'b0;
                if (score_valid) state_next = CONVERT;
            end
            CONVERT: begin
                if (bit_cnt == CNT_W'(CONV_BITS - 1)) state_next = COMMIT;
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sat_q       <= '0;
            bin_sh      <= '0;
            bcd_sh      <= '0;
            bit_cnt     <= '0;
            hi_bin      <= '0;
            score_BCD   <= '0;
            hiscore_BCD <= '0;
            new_hiscore <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (score_valid) begin
                        sat_q   <= sat_in;
                        bin_sh  <= sat_in;
                        bcd_sh  <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONVERT: begin
                    {bcd_sh, bin_sh} <= {bcd_adj, bin_sh} << 1;
                    bit_cnt          <= bit_cnt + 1'b1;
                end
                COMMIT: begin
                    score_BCD <= bcd_sh;
                    if (sat_q > hi_bin) begin
                        hiscore_BCD <= bcd_sh;
                        hi_bin      <= sat_q;
                        new_hiscore <= 1'b1;
                    end else begin
                        new_hiscore <= 1'b0;
                    end
                end
                default: ;
            endcase
            // A clear in the same cycle as a commit overrides the high-score update.
            if (clear_hiscore) begin
                hiscore_BCD <= '0;
                hi_bin      <= '0;
                new_hiscore <= 1'b0;
            end
        end
    end

`ifdef HISCORE_FLASH_EN
    logic [31:0] flash_cnt;
    logic        flash_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_cnt  <= '0;
            flash_flag <= 1'b0;
        end else if (clear_hiscore || !new_hiscore) begin
            flash_cnt  <= '0;
            flash_flag <= 1'b0;
        end else if (flash_cnt == 32'(FLASH_PERIOD - 1)) begin
            flash_cnt  <= '0;
            flash_flag <= ~flash_flag;
        end else begin
            flash_cnt <= flash_cnt + 32'd1;
        end
    end

    assign blank_hi = flash_flag;
`else
    assign blank_hi = 1'b0;
`endif

    // Segment order per digit is {g,f,e,d,c,b,a}; a lit segment is 0.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    assign seven_seg = {
        blank_hi ? 21'h1FFFFF
                 : {seg7(hiscore_BCD[11:8]), seg7(hiscore_BCD[7:4]), seg7(hiscore_BCD[3:0])},
        seg7(score_BCD[11:8]), seg7(score_BCD[7:4]), seg7(score_BCD[3:0])
    };

endmodule
